verify_round_ctrl: RTL and testbench

//  Verifier-side per-round sequencer, the receiving end of the signer round function.

---
 rtl/verify_round_ctrl_pkg.sv | 27 ++
 rtl/verify_round_ctrl.sv | 148 ++++++++++++++
 tb/tb_verify_round_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/verify_round_ctrl_pkg.sv
// Shared definitions for the verifier round sequencer: default widths,
// party count and the sequencer state encoding.
package verify_round_ctrl_pkg;

    localparam int N_PARTIES = 16;
    localparam int SEED_W    = 128;
    localparam int DIG_W     = 256;
    localparam int KEY_W     = 128;
    localparam int MSG_W     = 512;
    localparam int IDX_W     = 4;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        COM,
        NEXT,
        CH,
        CV,
        DONE
    } vr_state_e;

    // True when idx addresses the final party of a round of numParties parties.
    function automatic logic isLastParty(input logic [IDX_W-1:0] idx, input int numParties);
        return idx == IDX_W'(numParties - 1);
    endfunction

endpackage

// File: rtl/verify_round_ctrl.sv
// Verifier-side round sequencer. Rebuilds the party commitment vector C for
// one opened round: every opened party is recommitted through the shared
// commitment engine, the unopened party's commitment is copied from the
// signature. Afterwards the Ch and Cv hash engines are run in turn and the
// results are returned together with C to the round-loop controller.
// The engines live outside so the parent can share them with the signer.
module verify_round_ctrl
    import verify_round_ctrl_pkg::*;
#(
    parameter int NUM_PARTIES = N_PARTIES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         vr_start,
    input  logic [NUM_PARTIES*SEED_W-1:0] seeds,
    input  logic [IDX_W-1:0]             unopened,
    input  logic [DIG_W-1:0]             c_unopened,
    input  logic [KEY_W-1:0]             masked_key,
    input  logic [MSG_W-1:0]             msgs,
    output logic                         com_start,
    output logic [IDX_W-1:0]             com_party,
    output logic [SEED_W-1:0]            com_seed,
    input  logic                         com_end,
    input  logic [DIG_W-1:0]             com_digest,
    output logic                         ch_start,
    input  logic                         ch_end,
    input  logic [DIG_W-1:0]             ch_digest,
    output logic                         cv_start,
    input  logic                         cv_end,
    input  logic [DIG_W-1:0]             cv_digest,
    output logic [NUM_PARTIES*DIG_W-1:0] C,
    output logic [DIG_W-1:0]             Ch,
    output logic [DIG_W-1:0]             Cv,
    output logic                         vr_end
);

    vr_state_e                    state_q;
    logic [IDX_W-1:0]             cnt_q;
    logic                         com_start_q;
    logic                         ch_start_q;
    logic                         cv_start_q;
    logic [IDX_W-1:0]             com_party_q;
    logic [SEED_W-1:0]            com_seed_q;
    logic [NUM_PARTIES*DIG_W-1:0] c_q;
    logic [DIG_W-1:0]             ch_q;
    logic [DIG_W-1:0]             cv_q;
    logic                         vr_end_q;

    // masked_key and msgs are consumed by the Cv engine directly; they are
    // ports here only so the parent has a single place to route them from.
    logic unusedEngineInputs;
    assign unusedEngineInputs = ^{masked_key, msgs};

    // Engine requests are forced low while reset is high so an engine that
    // is being abandoned mid-request sees the request vanish immediately.
    assign com_start = com_start_q & ~reset;
    assign ch_start  = ch_start_q & ~reset;
    assign cv_start  = cv_start_q & ~reset;
    assign com_party = com_party_q;
    assign com_seed  = com_seed_q;
    assign C         = c_q;
    assign Ch        = ch_q;
    assign Cv        = cv_q;
    assign vr_end    = vr_end_q;

    // Round sequencer: walks every party, then Ch, then Cv. Each engine
    // state raises its start in its first cycle and only reacts to end once
    // that start is visible, so a stale end from an earlier request is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            com_start_q <= 1'b0;
            ch_start_q  <= 1'b0;
            cv_start_q  <= 1'b0;
            com_party_q <= '0;
            com_seed_q  <= '0;
            c_q         <= '0;
            ch_q        <= '0;
            cv_q        <= '0;
            vr_end_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!vr_start) begin
                        vr_end_q <= 1'b0;
                    end else if (!vr_end_q) begin
                        cnt_q   <= '0;
                        state_q <= SEL;
                    end
                end
                SEL: begin
                    if (cnt_q == unopened) begin
                        c_q[int'(cnt_q)*DIG_W +: DIG_W] <= c_unopened;
                        state_q <= NEXT;
                    end else begin
                        com_party_q <= cnt_q;
                        com_seed_q  <= seeds[int'(cnt_q)*SEED_W +: SEED_W];
                        state_q     <= COM;
                    end
                end
                COM: begin
                    if (!com_start_q) begin
                        com_start_q <= 1'b1;
                    end else if (com_end) begin
                        c_q[int'(cnt_q)*DIG_W +: DIG_W] <= com_digest;
                        com_start_q <= 1'b0;
                        state_q     <= NEXT;
                    end
                end
                NEXT: begin
                    if (isLastParty(cnt_q, NUM_PARTIES)) begin
                        state_q <= CH;
                    end else begin
                        cnt_q   <= cnt_q + IDX_W'(1);
                        state_q <= SEL;
                    end
                end
                CH: begin
                    if (!ch_start_q) begin
                        ch_start_q <= 1'b1;
                    end else if (ch_end) begin
                        ch_q       <= ch_digest;
                        ch_start_q <= 1'b0;
                        state_q    <= CV;
                    end
                end
                CV: begin
                    if (!cv_start_q) begin
                        cv_start_q <= 1'b1;
                    end else if (cv_end) begin
                        cv_q       <= cv_digest;
                        cv_start_q <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    vr_end_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_verify_round_ctrl.sv
// Directed bench for the verifier round sequencer, with stub engines that
// return predictable digests and optionally stall for a random time.
module tb_verify_round_ctrl;
    import verify_round_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic                        reset;
    logic                        vrStart;
    logic [N_PARTIES*SEED_W-1:0] seeds;
    logic [3:0]                  unopened;
    logic [DIG_W-1:0]            cUnopened;
    logic [KEY_W-1:0]            maskedKey;
    logic [MSG_W-1:0]            msgs;
    logic                        comStart, comEnd, chStart, chEnd, cvStart, cvEnd, vrEnd;
    logic [3:0]                  comParty;
    logic [SEED_W-1:0]           comSeed;
    logic [DIG_W-1:0]            comDigest, chDigest, cvDigest, chOut, cvOut;
    logic [N_PARTIES*DIG_W-1:0]  cOut;

    logic                        vrStart8;
    logic [8*SEED_W-1:0]         seeds8;
    logic [3:0]                  unopened8;
    logic [DIG_W-1:0]            cUnopened8;
    logic                        comStart8, comEnd8, chStart8, chEnd8, cvStart8, cvEnd8, vrEnd8;
    logic [3:0]                  comParty8;
    logic [SEED_W-1:0]           comSeed8;
    logic [DIG_W-1:0]            comDigest8, chDigest8, cvDigest8, chOut8, cvOut8;
    logic [8*DIG_W-1:0]          cOut8;

    verify_round_ctrl dut (
        .clk(clk), .reset(reset), .vr_start(vrStart), .seeds(seeds), .unopened(unopened),
        .c_unopened(cUnopened), .masked_key(maskedKey), .msgs(msgs),
        .com_start(comStart), .com_party(comParty), .com_seed(comSeed),
        .com_end(comEnd), .com_digest(comDigest),
        .ch_start(chStart), .ch_end(chEnd), .ch_digest(chDigest),
        .cv_start(cvStart), .cv_end(cvEnd), .cv_digest(cvDigest),
        .C(cOut), .Ch(chOut), .Cv(cvOut), .vr_end(vrEnd)
    );

    verify_round_ctrl #(.NUM_PARTIES(8)) dut8 (
        .clk(clk), .reset(reset), .vr_start(vrStart8), .seeds(seeds8), .unopened(unopened8),
        .c_unopened(cUnopened8), .masked_key(maskedKey), .msgs(msgs),
        .com_start(comStart8), .com_party(comParty8), .com_seed(comSeed8),
        .com_end(comEnd8), .com_digest(comDigest8),
        .ch_start(chStart8), .ch_end(chEnd8), .ch_digest(chDigest8),
        .cv_start(cvStart8), .cv_end(cvEnd8), .cv_digest(cvDigest8),
        .C(cOut8), .Ch(chOut8), .Cv(cvOut8), .vr_end(vrEnd8)
    );

    // Stub engines: commitment digest is 0x10+party, Ch folds the first two
    // slots of C, Cv echoes the masked key. forceEnd injects stray end pulses.
    bit         randomLat = 1'b0;
    bit         forceEnd  = 1'b0;
    logic [3:0] comWait = '0, chWait = '0, cvWait = '0;

    always @(posedge clk) begin
        if (!comStart) comWait <= randomLat ? 4'($urandom_range(7, 0)) : 4'd0;
        else if (comWait != 0) comWait <= comWait - 4'd1;
        if (!chStart) chWait <= randomLat ? 4'($urandom_range(7, 0)) : 4'd0;
        else if (chWait != 0) chWait <= chWait - 4'd1;
        if (!cvStart) cvWait <= randomLat ? 4'($urandom_range(7, 0)) : 4'd0;
        else if (cvWait != 0) cvWait <= cvWait - 4'd1;
    end

    assign comEnd     = (comStart && comWait == 0) || forceEnd;
    assign chEnd      = (chStart && chWait == 0) || forceEnd;
    assign cvEnd      = (cvStart && cvWait == 0) || forceEnd;
    assign comDigest  = {248'h0, 8'h10 + {4'h0, comParty}};
    assign chDigest   = cOut[255:0] ^ cOut[511:256];
    assign cvDigest   = {128'h0, maskedKey};

    assign comEnd8    = comStart8;
    assign chEnd8     = chStart8;
    assign cvEnd8     = cvStart8;
    assign comDigest8 = {248'h0, 8'h10 + {4'h0, comParty8}};
    assign chDigest8  = cOut8[255:0] ^ cOut8[511:256];
    assign cvDigest8  = {128'h0, maskedKey};

    // Protocol watcher: counts requests, records which parties were
    // requested and tallies handshake, overlap and seed violations.
    int          comReqs = 0, comReqs8 = 0, overlapViol = 0, gapViol = 0, seedViol = 0;
    logic [15:0] reqMask = '0;
    logic        prevCom = 1'b0, prevComEnd = 1'b0, prevCom8 = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (int'(comStart) + int'(chStart) + int'(cvStart) > 1) overlapViol++;
            if (comStart && !prevCom) begin
                comReqs++;
                reqMask[comParty] = 1'b1;
                if (comSeed !== seeds[comParty*SEED_W +: SEED_W]) seedViol++;
            end
            if (prevCom && prevComEnd && comStart) gapViol++;
            if (prevCom && !prevComEnd && !comStart) gapViol++;
            if (comStart8 && !prevCom8) comReqs8++;
        end
        prevCom    = comStart;
        prevComEnd = comEnd;
        prevCom8   = comStart8;
    end

    task automatic test_reset();
        reset = 1'b1; vrStart = 1'b0; vrStart8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (comStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_com_start got %b expected 0", comStart); end
        checks++; if (chStart !== 1'b0 || cvStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_hash_start got %b%b expected 00", chStart, cvStart); end
        checks++; if (comParty !== 4'h0) begin failures++; $display("[TB] FAIL reset_com_party got %h expected 0", comParty); end
        checks++; if (comSeed !== '0) begin failures++; $display("[TB] FAIL reset_com_seed got %h expected 0", comSeed); end
        checks++; if (cOut !== '0) begin failures++; $display("[TB] FAIL reset_C slot0 got %h expected all zero", cOut[255:0]); end
        checks++; if (chOut !== '0 || cvOut !== '0) begin failures++; $display("[TB] FAIL reset_Ch_Cv got %h / %h expected 0", chOut, cvOut); end
        checks++; if (vrEnd !== 1'b0 || vrEnd8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_vr_end got %b%b expected 00", vrEnd, vrEnd8); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One complete round on the 16-party instance with unopened party p.
    task automatic test_full_round(input logic [3:0] p, input bit checkLat);
        int               cycles, reqs0, ov0, gv0, sv0, expLat;
        logic [DIG_W-1:0] expSlot, expCh;
        logic [15:0]      expMask;
        vrStart = 1'b0;
        repeat (2) @(negedge clk);
        unopened  = p;
        cUnopened = {4{64'hC0DE_0000_0000_0000 | 64'(p)}};
        maskedKey = {64'hA5A5_0000_0000_0000 | 64'(p), 64'h0123_4567_89AB_CDEF};
        reqMask = '0; reqs0 = comReqs; ov0 = overlapViol; gv0 = gapViol; sv0 = seedViol;
        cycles = 0; expCh = '0;
        expLat = 1 + 4*(N_PARTIES-1) + 2 + 5;
        vrStart = 1'b1;
        while (cycles < 2000) begin
            @(posedge clk); #1; cycles++;
            if (vrEnd) break;
        end
        checks++; if (vrEnd !== 1'b1) begin failures++; $display("[TB] FAIL round_p%0d_done vr_end got %b expected 1 (timeout)", p, vrEnd); end
        if (checkLat) begin
            checks++; if (cycles !== expLat) begin failures++; $display("[TB] FAIL round_p%0d_latency got %0d expected %0d", p, cycles, expLat); end
        end
        checks++; if (comReqs - reqs0 !== N_PARTIES-1) begin failures++; $display("[TB] FAIL round_p%0d_requests got %0d expected %0d", p, comReqs - reqs0, N_PARTIES-1); end
        for (int i = 0; i < 16; i++) expMask[i] = (i != int'(p));
        checks++; if (reqMask !== expMask) begin failures++; $display("[TB] FAIL round_p%0d_party_mask got %h expected %h", p, reqMask, expMask); end
        for (int i = 0; i < N_PARTIES; i++) begin
            expSlot = (i == int'(p)) ? cUnopened : {248'h0, 8'h10 + 8'(i)};
            if (i < 2) expCh = expCh ^ expSlot;
            checks++;
            if (cOut[i*DIG_W +: DIG_W] !== expSlot) begin
                failures++;
                $display("[TB] FAIL round_p%0d_C%0d got %h expected %h", p, i, cOut[i*DIG_W +: DIG_W], expSlot);
            end
        end
        checks++; if (chOut !== expCh) begin failures++; $display("[TB] FAIL round_p%0d_Ch got %h expected %h", p, chOut, expCh); end
        checks++; if (cvOut !== {128'h0, maskedKey}) begin failures++; $display("[TB] FAIL round_p%0d_Cv got %h expected %h", p, cvOut, {128'h0, maskedKey}); end
        checks++;
        if (overlapViol != ov0 || gapViol != gv0 || seedViol != sv0) begin
            failures++;
            $display("[TB] FAIL round_p%0d_protocol overlap/gap/seed got %0d/%0d/%0d expected 0/0/0",
                     p, overlapViol - ov0, gapViol - gv0, seedViol - sv0);
        end
    endtask

    // Eight-party instance with an out-of-range unopened index: nothing skipped.
    task automatic test_n8_no_skip();
        int               cycles, reqs0;
        logic [DIG_W-1:0] expSlot;
        unopened8  = 4'd9;
        cUnopened8 = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        reqs0 = comReqs8; cycles = 0;
        @(negedge clk);
        vrStart8 = 1'b1;
        while (cycles < 2000) begin
            @(posedge clk); #1; cycles++;
            if (vrEnd8) break;
        end
        checks++; if (cycles !== 1 + 4*8 + 5) begin failures++; $display("[TB] FAIL n8_latency got %0d expected %0d", cycles, 1 + 4*8 + 5); end
        checks++; if (comReqs8 - reqs0 !== 8) begin failures++; $display("[TB] FAIL n8_requests got %0d expected 8", comReqs8 - reqs0); end
        for (int i = 0; i < 8; i++) begin
            expSlot = {248'h0, 8'h10 + 8'(i)};
            checks++;
            if (cOut8[i*DIG_W +: DIG_W] !== expSlot) begin
                failures++;
                $display("[TB] FAIL n8_C%0d got %h expected %h", i, cOut8[i*DIG_W +: DIG_W], expSlot);
            end
        end
        checks++; if (chOut8 !== {248'h0, 8'h01}) begin failures++; $display("[TB] FAIL n8_Ch got %h expected %h", chOut8, {248'h0, 8'h01}); end
        checks++; if (cvOut8 !== {128'h0, maskedKey}) begin failures++; $display("[TB] FAIL n8_Cv got %h expected %h", cvOut8, {128'h0, maskedKey}); end
        @(negedge clk);
        vrStart8 = 1'b0;
    endtask

    // Reset while party 7 is being committed, then stray end pulses in IDLE.
    task automatic test_reset_mid_run();
        bit found = 1'b0;
        vrStart = 1'b0;
        repeat (2) @(negedge clk);
        unopened = 4'd3;
        vrStart  = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (comStart && comParty == 4'd7) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("[TB] FAIL midreset_reach_party7 got 0 expected 1 (timeout)"); end
        reset = 1'b1;
        #1;
        checks++; if (comStart !== 1'b0) begin failures++; $display("[TB] FAIL midreset_start_immediate got %b expected 0", comStart); end
        @(posedge clk); #1;
        checks++; if (comStart !== 1'b0 || chStart !== 1'b0 || cvStart !== 1'b0) begin failures++; $display("[TB] FAIL midreset_starts got %b%b%b expected 000", comStart, chStart, cvStart); end
        checks++; if (comParty !== 4'h0 || comSeed !== '0) begin failures++; $display("[TB] FAIL midreset_party_seed got %h/%h expected 0/0", comParty, comSeed); end
        checks++; if (cOut !== '0 || chOut !== '0 || cvOut !== '0) begin failures++; $display("[TB] FAIL midreset_results C slot0 %h Ch %h expected all zero", cOut[255:0], chOut); end
        checks++; if (vrEnd !== 1'b0) begin failures++; $display("[TB] FAIL midreset_vr_end got %b expected 0", vrEnd); end
        @(negedge clk);
        vrStart  = 1'b0;
        forceEnd = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        forceEnd = 1'b0;
        checks++;
        if (vrEnd !== 1'b0 || comStart !== 1'b0 || chStart !== 1'b0 || cvStart !== 1'b0 || cOut !== '0 || chOut !== '0) begin
            failures++;
            $display("[TB] FAIL late_end_ignored vr_end %b starts %b%b%b Ch %h expected idle with zero results", vrEnd, comStart, chStart, cvStart, chOut);
        end
        test_full_round(4'd3, 1'b1);
    endtask

    // vr_start held after completion must not retrigger; a one-cycle drop does.
    task automatic test_hold_start();
        int r0, cycles;
        r0 = comReqs;
        repeat (10) @(negedge clk);
        checks++; if (vrEnd !== 1'b1) begin failures++; $display("[TB] FAIL hold_vr_end got %b expected 1", vrEnd); end
        checks++; if (comReqs !== r0 || comStart !== 1'b0) begin failures++; $display("[TB] FAIL hold_no_restart requests got %0d expected %0d", comReqs, r0); end
        vrStart = 1'b0;
        @(negedge clk);
        vrStart = 1'b1;
        @(posedge clk); #1;
        cycles = 1;
        checks++; if (vrEnd !== 1'b0) begin failures++; $display("[TB] FAIL rearm_vr_end_clear got %b expected 0", vrEnd); end
        while (cycles < 2000) begin
            @(posedge clk); #1; cycles++;
            if (vrEnd) break;
        end
        checks++; if (cycles !== 1 + 4*(N_PARTIES-1) + 2 + 5) begin failures++; $display("[TB] FAIL rearm_latency got %0d expected %0d", cycles, 1 + 4*(N_PARTIES-1) + 2 + 5); end
        checks++; if (comReqs - r0 !== N_PARTIES-1) begin failures++; $display("[TB] FAIL rearm_requests got %0d expected %0d", comReqs - r0, N_PARTIES-1); end
        @(negedge clk);
        vrStart = 1'b0;
    endtask

    initial begin
        msgs       = {16{32'h5EED_F00D}};
        unopened   = 4'd0; cUnopened  = '0; maskedKey = '0;
        unopened8  = 4'd0; cUnopened8 = '0;
        for (int i = 0; i < N_PARTIES; i++) seeds[i*SEED_W +: SEED_W] = {8'hA0 + 8'(i), 120'(i*7 + 3)};
        for (int i = 0; i < 8; i++) seeds8[i*SEED_W +: SEED_W] = {8'hB0 + 8'(i), 120'(i*5 + 1)};
        test_reset();
        test_full_round(4'd5, 1'b1);
        test_full_round(4'd0, 1'b1);
        test_full_round(4'd15, 1'b1);
        test_n8_no_skip();
        randomLat = 1'b1;
        test_full_round(4'd5, 1'b0);
        test_full_round(4'd10, 1'b0);
        randomLat = 1'b0;
        test_reset_mid_run();
        test_hold_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
